fusion_stream_v2: RTL and testbench

//  Parametrised successor of the per-beat frame fusion stage. Blends an aligned old/new frame pair
//  per pixel using a per-pixel weight map (HSSIM-derived, aligned upstream). Adds valid/ready

---
 rtl/fusion_stream_v2.sv | 151 +++++++++++++++
 tb/tb_fusion_stream_v2.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fusion_stream_v2.sv
// fusion_stream_v2: weight-map blend of old/new frame beats with valid/ready, per-frame mode and length check
module fusion_stream_v2 #(
   parameter int PIXELS_PER_BEAT = 16,
   parameter int PIX_W = 8,
   parameter int WGT_W = 8,
   parameter int IMAGE_DIM = 512
) (
   input  logic                               clk,
   input  logic                               aresetn,
   input  logic                               s_valid,
   output logic                               s_ready,
   input  logic                               s_last,
   input  logic [PIX_W*PIXELS_PER_BEAT-1:0]   s_old,
   input  logic [PIX_W*PIXELS_PER_BEAT-1:0]   s_new,
   input  logic [WGT_W*PIXELS_PER_BEAT-1:0]   s_wgt,
   input  logic [1:0]                         cfg_mode,
   output logic                               m_valid,
   input  logic                               m_ready,
   output logic                               m_last,
   output logic [PIX_W*PIXELS_PER_BEAT-1:0]   m_fused,
   output logic                               frame_done,
   output logic                               frame_err
);
   localparam int N = PIXELS_PER_BEAT;
   localparam int PW = PIX_W + WGT_W;
   localparam int BEATS = IMAGE_DIM * IMAGE_DIM / N;
   localparam int CW = $clog2(BEATS);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
   localparam logic [WGT_W-1:0] WMAX = '1;
   localparam logic [PW:0] HALF = (PW + 1)'(1) << (WGT_W - 1);
   localparam logic [1:0] M_BLEND = 2'd1;
   localparam logic [1:0] M_OLD = 2'd2;
   localparam logic [1:0] M_NEW = 2'd3;
   logic adv, acc, start, last_beat;
   logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
   logic [1:0] mode_q, mode_d, md1_q, md1_d, md2_q, md2_d;
   logic [PIX_W*N-1:0] old1_q, old1_d, new1_q, new1_d, old2_q, old2_d, new2_q, new2_d, fused_q, fused_d;
   logic [WGT_W*N-1:0] w1_q, w1_d, wc1_q, wc1_d, w2_q, w2_d;
   logic [PW*N-1:0] po2_q, po2_d, pn2_q, pn2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic done_q, done_d, err_q, err_d;
   logic [PW:0] sum;
   logic [PIX_W-1:0] o, n, bl;
   logic [WGT_W-1:0] w;
   assign adv = ~v3_q | m_ready;
   assign acc = s_valid & adv;
   assign start = cnt_q == '0;
   assign last_beat = cnt_q == LAST_BEAT;
   assign s_ready = adv;
   assign m_valid = v3_q;
   assign m_last = l3_q;
   assign m_fused = fused_q;
   assign frame_done = done_q;
   assign frame_err = err_q;
   always_comb begin
      v1_d = adv ? s_valid : v1_q;
      v2_d = adv ? v1_q : v2_q;
      v3_d = adv ? v2_q : v3_q;
      l1_d = adv ? s_last : l1_q;
      l2_d = adv ? l1_q : l2_q;
      l3_d = adv ? l2_q : l3_q;
      mode_d = (acc & start) ? cfg_mode : mode_q;
      md1_d = adv ? (start ? cfg_mode : mode_q) : md1_q;
      md2_d = adv ? md1_q : md2_q;
      old1_d = adv ? s_old : old1_q;
      new1_d = adv ? s_new : new1_q;
      w1_d = adv ? s_wgt : w1_q;
      old2_d = adv ? old1_q : old2_q;
      new2_d = adv ? new1_q : new2_q;
      w2_d = adv ? w1_q : w2_q;
      wc1_d = wc1_q;
      po2_d = po2_q;
      pn2_d = pn2_q;
      fused_d = fused_q;
      sum = '0;
      o = '0;
      n = '0;
      w = '0;
      bl = '0;
      for (int j = 0; j < N; j++) begin
         wc1_d[j*WGT_W +: WGT_W] = adv ? WMAX - s_wgt[j*WGT_W +: WGT_W] : wc1_q[j*WGT_W +: WGT_W];
         po2_d[j*PW +: PW] = adv ? PW'(old1_q[j*PIX_W +: PIX_W]) * PW'(wc1_q[j*WGT_W +: WGT_W]) : po2_q[j*PW +: PW];
         pn2_d[j*PW +: PW] = adv ? PW'(new1_q[j*PIX_W +: PIX_W]) * PW'(w1_q[j*WGT_W +: WGT_W]) : pn2_q[j*PW +: PW];
         o = old2_q[j*PIX_W +: PIX_W];
         n = new2_q[j*PIX_W +: PIX_W];
         w = w2_q[j*WGT_W +: WGT_W];
         sum = (PW + 1)'(po2_q[j*PW +: PW]) + (PW + 1)'(pn2_q[j*PW +: PW]) + HALF;
         bl = PIX_W'(sum >> WGT_W);
         // hard-select differs from blend only in lacking the exact-new endpoint at WMAX
         fused_d[j*PIX_W +: PIX_W] = !adv ? fused_q[j*PIX_W +: PIX_W] :
                                     md2_q == M_OLD ? o :
                                     md2_q == M_NEW ? n :
                                     w == '0 ? o :
                                     (md2_q == M_BLEND && w == WMAX) ? n : bl;
      end
      // a long frame wraps to 0 so the next beat is treated as a fresh frame start
      cnt_d = acc ? ((s_last | last_beat) ? '0 : cnt_q + CW'(1)) : cnt_q;
      err_d = acc & (s_last ^ last_beat);
      done_d = v3_q & m_ready & l3_q;
   end
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         l1_q <= 1'b0;
         l2_q <= 1'b0;
         l3_q <= 1'b0;
         mode_q <= '0;
         md1_q <= '0;
         md2_q <= '0;
         old1_q <= '0;
         new1_q <= '0;
         w1_q <= '0;
         wc1_q <= '0;
         old2_q <= '0;
         new2_q <= '0;
         w2_q <= '0;
         po2_q <= '0;
         pn2_q <= '0;
         fused_q <= '0;
         cnt_q <= '0;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         l1_q <= l1_d;
         l2_q <= l2_d;
         l3_q <= l3_d;
         mode_q <= mode_d;
         md1_q <= md1_d;
         md2_q <= md2_d;
         old1_q <= old1_d;
         new1_q <= new1_d;
         w1_q <= w1_d;
         wc1_q <= wc1_d;
         old2_q <= old2_d;
         new2_q <= new2_d;
         w2_q <= w2_d;
         po2_q <= po2_d;
         pn2_q <= pn2_d;
         fused_q <= fused_d;
         cnt_q <= cnt_d;
         done_q <= done_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_fusion_stream_v2.sv
// tb_fusion_stream_v2: scoreboard bench with directed beats, backpressure, frame-length and reset cases
module tb_fusion_stream_v2;
   localparam int P = 16;
   localparam int DIM = 64;
   localparam int BEATS = DIM * DIM / P;
   localparam int DW = P * 8;
   localparam logic [31:0] T_O = 32'h20FF1040;
   localparam logic [31:0] T_N = 32'h6000F0C0;
   localparam logic [31:0] T_W = 32'h40800180;
   localparam logic [31:0] T_E = 32'h307F1180;
   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      int            a;
   } exp_t;
   logic clk = 0, aresetn = 0, s_valid = 0, s_ready, s_last = 0;
   logic m_valid, m_ready = 1, m_last, frame_done, frame_err, bp_en = 0;
   logic [DW-1:0] s_old = '0, s_new = '0, s_wgt = '0, m_fused;
   logic [1:0] cfg_mode = '0;
   exp_t q[$];
   int n_chk = 0, n_fail = 0, adv_cnt = 0, cnt_m = 0, err_seen = 0, done_seen = 0, rcyc = 0;
   logic err_pend = 0, err_exp = 0, done_exp = 0, held = 0, held_l = 0;
   logic [DW-1:0] held_d = '0;

   fusion_stream_v2 #(.PIXELS_PER_BEAT(P), .PIX_W(8), .WGT_W(8), .IMAGE_DIM(DIM)) dut (
      .clk(clk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
      .s_old(s_old), .s_new(s_new), .s_wgt(s_wgt), .cfg_mode(cfg_mode), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last), .m_fused(m_fused), .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rep(input logic [7:0] b);
      return {P{b}};
   endfunction

   function automatic logic [DW-1:0] ramp(input int i);
      logic [DW-1:0] v;
      v = '0;
      for (int j = 0; j < P; j++) v[j*8 +: 8] = 8'(i * 3 + j * 17);
      return v;
   endfunction

   function automatic logic [DW-1:0] tab(input int f);
      logic [DW-1:0] v;
      v = '0;
      for (int j = 0; j < P; j++)
         v[j*8 +: 8] = f == 0 ? T_O[(j%4)*8 +: 8] : f == 1 ? T_N[(j%4)*8 +: 8] :
                       f == 2 ? T_W[(j%4)*8 +: 8] : T_E[(j%4)*8 +: 8];
      return v;
   endfunction

   task automatic send(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [DW-1:0] w,
                       input logic l, input logic [1:0] md, input logic [DW-1:0] e);
      int t;
      bit ok;
      exp_t x;
      t = 0;
      ok = 0;
      while (!ok) begin
         @(negedge clk);
         s_valid = 1; s_old = o; s_new = n; s_wgt = w; s_last = l; cfg_mode = md;
         #1;
         if (s_ready) begin
            x.d = e; x.l = l; x.a = adv_cnt;
            q.push_back(x);
            err_pend = (l && cnt_m != BEATS - 1) || (!l && cnt_m == BEATS - 1);
            cnt_m = (l || cnt_m == BEATS - 1) ? 0 : cnt_m + 1;
            ok = 1;
         end else if (++t > 50) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: s_ready stayed 0, required 1 within 50 cycles");
            ok = 1;
         end
      end
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(negedge clk);
         s_valid = 0;
      end
   endtask

   task automatic frame_beats(input int i0, input int i1, input int last_at, input logic [1:0] md,
                              input logic [DW-1:0] w, input bit pick_new);
      for (int i = i0; i <= i1; i++)
         send(ramp(i), ~ramp(i), w, i == last_at, md, pick_new ? ~ramp(i) : ramp(i));
   endtask

   initial forever begin
      @(negedge clk);
      rcyc++;
      m_ready = !bp_en || (rcyc % 2 == 0);
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (!aresetn) begin
         err_exp = 0; done_exp = 0; held = 0;
      end else begin
         chk("frame_err", DW'(frame_err), DW'(err_exp));
         chk("frame_done", DW'(frame_done), DW'(done_exp));
         err_seen += int'(frame_err);
         done_seen += int'(frame_done);
         err_exp = err_pend;
         err_pend = 0;
         done_exp = 0;
         if (held) begin
            chk("hold_valid", DW'(m_valid), DW'(1));
            chk("hold_data", m_fused, held_d);
            chk("hold_last", DW'(m_last), DW'(held_l));
         end
         chk("s_ready_adv", DW'(s_ready), DW'(!m_valid || m_ready));
         if (m_valid && m_ready) begin
            if (q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_beat: got %h with no beat outstanding", m_fused);
            end else begin
               e = q.pop_front();
               chk("fused", m_fused, e.d);
               chk("last", DW'(m_last), DW'(e.l));
               chk("latency", DW'(adv_cnt - e.a), DW'(3));
               done_exp = e.l;
            end
         end
         held = m_valid && !m_ready;
         held_d = m_fused;
         held_l = m_last;
         if (!m_valid || m_ready) adv_cnt++;
      end
   end

   initial begin
      int t;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_m_valid", DW'(m_valid), '0);
      chk("rst_m_last", DW'(m_last), '0);
      chk("rst_m_fused", m_fused, '0);
      chk("rst_frame_done", DW'(frame_done), '0);
      chk("rst_frame_err", DW'(frame_err), '0);
      chk("rst_s_ready", DW'(s_ready), DW'(1));
      @(negedge clk);
      aresetn = 1;
      // frame A: blend mode, endpoints, mixed weights, then a backpressured run
      send(rep(8'h40), rep(8'hC0), rep(8'h80), 0, 2'd1, rep(8'h80));
      send(ramp(1), ~ramp(1), '0, 0, 2'd1, ramp(1));
      send(ramp(2), ~ramp(2), '1, 0, 2'd1, ~ramp(2));
      send(tab(0), tab(1), tab(2), 0, 2'd1, tab(3));
      bp_en = 1;
      frame_beats(4, 13, -1, 2'd1, '1, 1);
      idle(3);
      bp_en = 0;
      frame_beats(14, 255, 255, 2'd1, '0, 0);
      idle(8);
      chk("frameA_done", DW'(done_seen), DW'(1));
      chk("frameA_err", DW'(err_seen), DW'(0));
      // frame B: pass-old latched, mid-frame switch to pass-new ignored
      frame_beats(0, 5, -1, 2'd2, rep(8'h5A), 0);
      frame_beats(6, 255, 255, 2'd3, rep(8'h5A), 0);
      idle(8);
      chk("frameB_done", DW'(done_seen), DW'(2));
      chk("frameB_err", DW'(err_seen), DW'(0));
      // frame C: pass-new, short frame ending at beat 100
      frame_beats(0, 100, 100, 2'd3, rep(8'h5A), 1);
      idle(8);
      chk("frameC_done", DW'(done_seen), DW'(3));
      chk("frameC_err", DW'(err_seen), DW'(1));
      // frame D: hard-select, full length
      send(tab(0), tab(1), tab(2), 0, 2'd0, tab(3));
      send(ramp(1), ~ramp(1), '0, 0, 2'd0, ramp(1));
      frame_beats(2, 255, 255, 2'd0, '0, 0);
      idle(8);
      chk("frameD_done", DW'(done_seen), DW'(4));
      chk("frameD_err", DW'(err_seen), DW'(1));
      // frame E: long frame wraps, the wrapped beat samples pass-new
      frame_beats(0, 255, -1, 2'd1, '0, 0);
      frame_beats(300, 302, -1, 2'd3, rep(8'h33), 1);
      @(negedge clk);
      chk("inflight_m_valid", DW'(m_valid), DW'(1));
      aresetn = 0;
      s_valid = 0;
      #1;
      chk("midrst_m_valid", DW'(m_valid), '0);
      q.delete();
      cnt_m = 0;
      err_pend = 0;
      repeat (2) @(negedge clk);
      aresetn = 1;
      idle(8);
      chk("frameE_err", DW'(err_seen), DW'(2));
      chk("postrst_no_done", DW'(done_seen), DW'(4));
      // frame F: first beat after reset is a frame start
      frame_beats(0, 3, -1, 2'd2, rep(8'h77), 0);
      idle(8);
      t = 0;
      while (q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_empty", DW'(q.size()), '0);
      chk("final_done", DW'(done_seen), DW'(4));
      chk("final_err", DW'(err_seen), DW'(2));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
